uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the SoC's single UART transmitter (the byte stream that drives `externalPins_uart_tx`) between N independent byte-stream requesters, e.g. CPU MMIO console and hardware PC-trace reporter. Grants are packet-atomic: a requester keeps the transmitter from its first byte through its `last` byte. Selection among waiting requesters is round-robin. A hold timeout reclaims the transmitter from a requester that stalls mid-packet. Sits between the requesters and the UART TX serializer inside SoCFull.

## Interface
- `N`, 2 — number of requesters, 2..8.
- `HOLD_MAX`, 64 — consecutive idle cycles a locked owner may stall before forced release, 1..65535.

- `clock` in 1 — sole clock; all state on rising edge.
- `resetn` in 1 — asynchronous, active-low reset.
- `req_mask` in N — quasi-static enable per requester; masked requesters are never granted.
- `req_valid` in N — requester i has a byte.
- `req_data` in 8*N — byte of requester i, at bits [8i+7:8i].
- `req_last` in N — byte of requester i is the final byte of its packet.
- `req_ready` out N — byte of requester i is accepted this cycle.
- `tx_valid` out 1 — byte offered to the serializer.
- `tx_data` out 8 — byte to the serializer.
- `tx_ready` in 1 — serializer accepts `tx_data` this cycle.
- `grant` out N — one-hot current owner; all zero when IDLE.
- `timeout` out 1 — one-cycle pulse on forced release.

## Operation
- FSM states: IDLE and LOCKED. Registers: `owner` (index), `ptr` (round-robin pointer, log2 N bits), `hold_cnt` (16 bits).
- IDLE:
  - The eligible set is `req_valid & req_mask`.
  - If the set is non-empty, choose the first eligible index at or after `ptr`, wrapping modulo N.
  - Register that index into `owner`, go to LOCKED, clear `hold_cnt`.
  - In IDLE, `tx_valid`=0 and `req_ready`=0.
- LOCKED, combinational pass-through from the owner o:
  - `tx_valid` = `req_valid[o]`, `tx_data` = `req_data[o]`, `req_ready[o]` = `tx_ready`.
  - All other `req_ready` bits are 0.
- Beat transfer: `tx_valid & tx_ready`.
- Release on last: a beat with `req_last[o]`=1 transfers → go IDLE, `ptr` ← (o+1) mod N.
- Stall counting:
  - Each LOCKED cycle with `req_valid[o]`=0 increments `hold_cnt`.
  - Any cycle with `req_valid[o]`=1 clears it.
- Forced release: `hold_cnt` reaches HOLD_MAX−1 while `req_valid[o]`=0 → go IDLE, `ptr` ← (o+1) mod N, pulse `timeout` the next cycle.
  - Forced release only occurs while `tx_valid`=0, so the serializer never sees a byte withdrawn.
- `req_mask[o]` deasserting while LOCKED does not revoke the grant. The packet completes or times out.
- Increments of `ptr` wrap modulo N, including non-power-of-2 N.

## Timing
- Reset values (async on `resetn` low, held until release):
  - `grant`=0, `tx_valid`=0, `tx_data`=0, `req_ready`=0, `timeout`=0.
  - `ptr`=0, `hold_cnt`=0, state IDLE.
- Reset mid-packet drops ownership immediately. The partial packet is abandoned with no replay.
- Grant latency:
  - A request first seen in IDLE at cycle t gives `grant` and pass-through `tx_valid` at t+1.
  - The earliest transfer is at t+1.
- Back-to-back packets:
  - Last beat transfers at t → IDLE at t+1 → next owner's first beat at t+2.
  - Exactly one bubble between packets.
- Simultaneous requests in IDLE: only the round-robin winner is granted; the others wait in IDLE.
- Sustained throughput within a packet: one byte per cycle when `tx_ready`=1.
- `timeout` is high for exactly one cycle, aligned with the first IDLE cycle after forced release.

## Test plan
- Single requester:
  - Stimulus: requester 0 sends 3 bytes 0x41, 0x42, 0x43 (last on 0x43) with `tx_ready`=1.
  - Required: `grant`=01 from cycle 1, bytes on `tx_data` at cycles 1–3, `grant`=00 at cycle 4, `ptr`=1.
- Contention:
  - Stimulus: both requesters raise valid at cycle 0, each sending a 2-byte packet.
  - Required: owner 0 at cycles 1–2, bubble at 3, owner 1 at cycles 4–5.
  - Then, with both requesting again, owner 0 wins next.
- Backpressure:
  - Stimulus: `tx_ready` toggles 1,0,0,1 during requester 1's packet.
  - Required: `req_ready[1]` mirrors `tx_ready`, `req_ready[0]`=0 throughout, no byte duplicated or lost.
- Stall timeout:
  - Stimulus: HOLD_MAX=4; requester 0 sends 1 non-last byte, then drops valid while requester 1 is waiting.
  - Required: forced release after 4 idle cycles, `timeout` pulse for 1 cycle, requester 1 granted the following cycle.
- Mask and wrap:
  - Stimulus: N=3, `req_mask`=101, all valid, `ptr`=1.
  - Required: requester 2 granted, then requester 0; requester 1 never granted.
- Reset mid-packet:
  - Stimulus: assert `resetn`=0 asynchronously mid-packet.
  - Required: all outputs zero within the same cycle; after release, a new request is granted with `ptr`=0 ordering.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one UART TX byte stream among N requesters.
// The current owner keeps the stream until its last byte, or until it stalls for HOLD_MAX idle cycles.
module uart_tx_arbiter #(
   parameter int N        = 2,
   parameter int HOLD_MAX = 64
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic [N-1:0]     req_mask,
   input  logic [N-1:0]     req_valid,
   input  logic [8*N-1:0]   req_data,
   input  logic [N-1:0]     req_last,
   output logic [N-1:0]     req_ready,
   output logic             tx_valid,
   output logic [7:0]       tx_data,
   input  logic             tx_ready,
   output logic [N-1:0]     grant,
   output logic             timeout
);

   localparam int          IW       = $clog2(N);
   localparam logic [0:0]  S_IDLE   = 1'b0;
   localparam logic [0:0]  S_LOCKED = 1'b1;
   localparam logic [15:0] HOLD_LIM = 16'(HOLD_MAX - 1);

   logic [0:0]    r_state;
   logic [IW-1:0] r_owner;
   logic [IW-1:0] r_ptr;
   logic [15:0]   r_hold_cnt;
   logic [N-1:0]  r_grant;
   logic          r_timeout;

   logic [N-1:0]  w_elig;
   logic          w_found;
   logic [IW-1:0] w_pick;
   logic [IW-1:0] w_cand;
   logic          w_hit;
   logic [IW-1:0] w_next;
   logic [N-1:0]  w_pick_onehot;
   logic          w_own_valid;
   logic          w_own_last;
   logic [7:0]    w_own_data;
   logic          w_locked;
   logic          w_beat;
   logic          w_release_last;
   logic          w_release_stall;

   assign w_elig          = req_valid & req_mask;
   assign w_locked        = (r_state == S_LOCKED);
   assign w_next          = (r_owner == IW'(N - 1)) ? {IW{1'b0}} : r_owner + 1'b1;
   assign w_pick_onehot   = {{(N-1){1'b0}}, 1'b1} << w_pick;
   assign w_beat          = w_locked & w_own_valid & tx_ready;
   assign w_release_last  = w_beat & w_own_last;
   assign w_release_stall = w_locked & ~w_own_valid & (r_hold_cnt == HOLD_LIM);
   assign grant           = r_grant;
   assign timeout         = r_timeout;

   // Round-robin search: first eligible index at or after the pointer, wrapping modulo N.
   always_comb begin
      w_found = 1'b0;
      w_pick  = {IW{1'b0}};
      w_cand  = {IW{1'b0}};
      w_hit   = 1'b0;
      for (int k = 0; k < N; k++) begin
         w_cand  = IW'((int'(r_ptr) + k) % N);
         w_hit   = w_elig[w_cand] & ~w_found;
         w_pick  = w_hit ? w_cand : w_pick;
         w_found = w_found | w_hit;
      end
   end

   // Select the owner's byte, valid and last flag.
   always_comb begin
      w_own_valid = 1'b0;
      w_own_last  = 1'b0;
      w_own_data  = 8'd0;
      for (int i = 0; i < N; i++) begin
         w_own_valid = (r_owner == IW'(i)) ? req_valid[i]      : w_own_valid;
         w_own_last  = (r_owner == IW'(i)) ? req_last[i]       : w_own_last;
         w_own_data  = (r_owner == IW'(i)) ? req_data[8*i +: 8] : w_own_data;
      end
   end

   // Pass-through to the serializer while locked; everything quiet while idle.
   always_comb begin
      tx_valid  = 1'b0;
      tx_data   = 8'd0;
      req_ready = {N{1'b0}};
      if (w_locked) begin
         tx_valid  = w_own_valid;
         tx_data   = w_own_data;
         req_ready = r_grant & {N{tx_ready}};
      end else begin
         tx_valid  = 1'b0;
         tx_data   = 8'd0;
         req_ready = {N{1'b0}};
      end
   end

   // Ownership FSM, round-robin pointer, stall counter and timeout pulse.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state    <= S_IDLE;
         r_owner    <= {IW{1'b0}};
         r_ptr      <= {IW{1'b0}};
         r_hold_cnt <= 16'd0;
         r_grant    <= {N{1'b0}};
         r_timeout  <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_hold_cnt <= 16'd0;
               if (w_found) begin
                  r_state <= S_LOCKED;
                  r_owner <= w_pick;
                  r_grant <= w_pick_onehot;
               end else begin
                  r_grant <= {N{1'b0}};
               end
            end
            S_LOCKED: begin
               // A stalled owner is only reclaimed while it offers nothing, so no byte is withdrawn.
               if (w_release_last || w_release_stall) begin
                  r_state    <= S_IDLE;
                  r_ptr      <= w_next;
                  r_grant    <= {N{1'b0}};
                  r_hold_cnt <= 16'd0;
                  r_timeout  <= w_release_stall;
               end else if (w_own_valid) begin
                  r_hold_cnt <= 16'd0;
               end else begin
                  r_hold_cnt <= r_hold_cnt + 16'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_grant <= {N{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N=3, HOLD_MAX=4): per-cycle comparison against a
// transaction-level model, plus hand-computed grant/byte/timeout expectations per scenario.
module tb_uart_tx_arbiter;

   localparam int N        = 3;
   localparam int HOLD_MAX = 4;

   logic           clock = 1'b0;
   logic           resetn;
   logic [N-1:0]   req_mask;
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic           tx_valid;
   logic [7:0]     tx_data;
   logic           tx_ready;
   logic [N-1:0]   grant;
   logic           timeout;

   always #5 clock = ~clock;

   uart_tx_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
      .clock(clock), .resetn(resetn), .req_mask(req_mask), .req_valid(req_valid),
      .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .grant(grant), .timeout(timeout)
   );

   int n_checks = 0;
   int n_errors = 0;
   int n_timeouts = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Requester sources: each queue entry is {last, byte}.
   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [8:0] q2[$];
   logic [N-1:0] pause;
   logic [7:0] tx_log[$];

   function automatic logic [8:0] qhead(input int i);
      logic [8:0] h;
      h = 9'd0;
      case (i)
         0: if (q0.size() > 0) h = q0[0];
         1: if (q1.size() > 0) h = q1[0];
         2: if (q2.size() > 0) h = q2[0];
         default: h = 9'd0;
      endcase
      return h;
   endfunction

   function automatic int qsize(input int i);
      case (i)
         0: return q0.size();
         1: return q1.size();
         2: return q2.size();
         default: return 0;
      endcase
   endfunction

   task automatic drive();
      logic [8:0] h;
      for (int i = 0; i < N; i++) begin
         h = qhead(i);
         req_valid[i]        = (qsize(i) > 0) && !pause[i];
         req_data[8*i +: 8]  = h[7:0];
         req_last[i]         = h[8];
      end
   endtask

   logic [N-1:0] s_grant;
   logic [N-1:0] s_rdy;
   logic         s_txv;
   logic [7:0]   s_txd;
   logic         s_to;

   // One cycle: present heads, sample at negedge, pop accepted bytes just after the next posedge.
   task automatic tick();
      logic [N-1:0] acc;
      logic [8:0]   tmp;
      drive();
      @(negedge clock);
      s_grant = grant; s_rdy = req_ready; s_txv = tx_valid; s_txd = tx_data; s_to = timeout;
      acc = req_valid & req_ready;
      if (tx_valid && tx_ready) tx_log.push_back(tx_data);
      if (timeout) n_timeouts++;
      @(posedge clock);
      #1;
      if (acc[0]) tmp = q0.pop_front();
      if (acc[1]) tmp = q1.pop_front();
      if (acc[2]) tmp = q2.pop_front();
   endtask

   // Model: owner index (-1 when nobody holds the stream), pointer, consecutive idle count.
   int   m_owner;
   int   m_ptr;
   int   m_idle;
   logic m_to;

   always @(posedge clock or negedge resetn) begin
      int o, p, h, idx;
      logic t;
      if (!resetn) begin
         m_owner <= -1; m_ptr <= 0; m_idle <= 0; m_to <= 1'b0;
      end else begin
         o = m_owner; p = m_ptr; h = m_idle; t = 1'b0;
         if (o < 0) begin
            for (int k = 0; k < N; k++) begin
               idx = (p + k) % N;
               if (o < 0 && req_valid[idx] && req_mask[idx]) begin
                  o = idx; h = 0;
               end
            end
         end else if (req_valid[o] && tx_ready && req_last[o]) begin
            p = (o + 1) % N; o = -1; h = 0;
         end else if (!req_valid[o]) begin
            h = h + 1;
            if (h == HOLD_MAX) begin
               p = (o + 1) % N; o = -1; h = 0; t = 1'b1;
            end
         end else begin
            h = 0;
         end
         m_owner <= o; m_ptr <= p; m_idle <= h; m_to <= t;
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clock) begin
      logic [N-1:0] eg, er;
      logic         ev;
      logic [7:0]   ed;
      eg = '0; er = '0; ev = 1'b0; ed = 8'd0;
      if (m_owner >= 0) begin
         eg = {{(N-1){1'b0}}, 1'b1} << m_owner;
         ev = req_valid[m_owner];
         ed = req_data[8*m_owner +: 8];
         er = tx_ready ? eg : '0;
      end
      chk("model grant", 32'(grant), 32'(eg));
      chk("model tx_valid", 32'(tx_valid), 32'(ev));
      chk("model tx_data", 32'(tx_data), 32'(ed));
      chk("model req_ready", 32'(req_ready), 32'(er));
      chk("model timeout", 32'(timeout), 32'(m_to));
   end

   int eg_cont[13] = '{0, 1, 1, 0, 2, 2, 0, 1, 1, 0, 2, 2, 0};
   int eg_single[5] = '{0, 1, 1, 1, 0};
   int ed_single[5] = '{0, 'h41, 'h42, 'h43, 0};
   int bp_ready[8]  = '{1, 1, 0, 0, 1, 1, 1, 1};
   int eg_bp[8]     = '{0, 2, 2, 2, 2, 0, 1, 0};
   int er_bp[8]     = '{0, 2, 0, 0, 2, 0, 1, 0};
   int eg_st[9]     = '{0, 1, 1, 1, 1, 1, 0, 2, 0};
   int ev_st[9]     = '{0, 1, 0, 0, 0, 0, 0, 1, 0};
   int et_st[9]     = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
   int eg_mask[6]   = '{0, 4, 0, 1, 0, 0};
   int eg_rst[5]    = '{0, 1, 0, 2, 0};
   logic [7:0] exp_log[22] = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h12, 8'h13, 8'h22, 8'h23,
                               8'h41, 8'h42, 8'h43, 8'h55, 8'h66, 8'h77, 8'h30, 8'h40,
                               8'h99, 8'hC2, 8'hA0, 8'hE0, 8'hF0, 8'hF1};

   initial begin
      resetn = 1'b0; tx_ready = 1'b1; req_mask = 3'b011; pause = '0;
      req_valid = '0; req_data = '0; req_last = '0;
      repeat (3) @(posedge clock);
      #1;
      chk("reset grant", 32'(grant), 32'd0);
      chk("reset tx_valid", 32'(tx_valid), 32'd0);
      chk("reset tx_data", 32'(tx_data), 32'd0);
      chk("reset req_ready", 32'(req_ready), 32'd0);
      chk("reset timeout", 32'(timeout), 32'd0);
      resetn = 1'b1;
      repeat (2) tick();

      // Contention: both requesters, two 2-byte packets each, starting from pointer 0.
      q0.push_back({1'b0, 8'h10}); q0.push_back({1'b1, 8'h11});
      q1.push_back({1'b0, 8'h20}); q1.push_back({1'b1, 8'h21});
      for (int c = 0; c < 13; c++) begin
         if (c == 6) begin
            q0.push_back({1'b0, 8'h12}); q0.push_back({1'b1, 8'h13});
            q1.push_back({1'b0, 8'h22}); q1.push_back({1'b1, 8'h23});
         end
         tick();
         chk($sformatf("contention grant c%0d", c), 32'(s_grant), 32'(eg_cont[c]));
      end

      // Single requester, three bytes.
      q0.push_back({1'b0, 8'h41}); q0.push_back({1'b0, 8'h42}); q0.push_back({1'b1, 8'h43});
      for (int c = 0; c < 5; c++) begin
         tick();
         chk($sformatf("single grant c%0d", c), 32'(s_grant), 32'(eg_single[c]));
         chk($sformatf("single tx_data c%0d", c), 32'(s_txd), 32'(ed_single[c]));
      end

      // Backpressure on requester 1 while requester 0 waits.
      q1.push_back({1'b0, 8'h55}); q1.push_back({1'b1, 8'h66});
      q0.push_back({1'b1, 8'h77});
      for (int c = 0; c < 8; c++) begin
         tx_ready = bp_ready[c][0];
         tick();
         chk($sformatf("backpressure grant c%0d", c), 32'(s_grant), 32'(eg_bp[c]));
         chk($sformatf("backpressure req_ready c%0d", c), 32'(s_rdy), 32'(er_bp[c]));
      end
      tx_ready = 1'b1;

      // Stall timeout: requester 0 goes quiet mid-packet while requester 1 waits.
      q0.push_back({1'b0, 8'h30}); q0.push_back({1'b1, 8'h31});
      for (int c = 0; c < 9; c++) begin
         if (c == 2) begin
            pause[0] = 1'b1;
            q1.push_back({1'b1, 8'h40});
         end
         tick();
         chk($sformatf("stall grant c%0d", c), 32'(s_grant), 32'(eg_st[c]));
         chk($sformatf("stall tx_valid c%0d", c), 32'(s_txv), 32'(ev_st[c]));
         chk($sformatf("stall timeout c%0d", c), 32'(s_to), 32'(et_st[c]));
      end
      q0.delete();
      pause = '0;

      // Move the pointer to 1, then mask requester 1 with all three requesting.
      q0.push_back({1'b1, 8'h99});
      for (int c = 0; c < 3; c++) tick();
      req_mask = 3'b101;
      q0.push_back({1'b1, 8'hA0}); q1.push_back({1'b1, 8'hB1}); q2.push_back({1'b1, 8'hC2});
      for (int c = 0; c < 6; c++) begin
         tick();
         chk($sformatf("mask grant c%0d", c), 32'(s_grant), 32'(eg_mask[c]));
      end
      chk("masked requester untouched", 32'(q1.size()), 32'd1);
      q1.delete();
      req_mask = 3'b011;
      tick();

      // Asynchronous reset in the middle of a packet.
      q0.push_back({1'b0, 8'hE0}); q0.push_back({1'b0, 8'hE1}); q0.push_back({1'b1, 8'hE2});
      tick();
      tick();
      drive();
      #1;
      chk("pre-reset tx_valid", 32'(tx_valid), 32'd1);
      chk("pre-reset tx_data", 32'(tx_data), 32'hE1);
      #1;
      resetn = 1'b0;
      #1;
      chk("async reset grant", 32'(grant), 32'd0);
      chk("async reset tx_valid", 32'(tx_valid), 32'd0);
      chk("async reset tx_data", 32'(tx_data), 32'd0);
      chk("async reset req_ready", 32'(req_ready), 32'd0);
      chk("async reset timeout", 32'(timeout), 32'd0);
      q0.delete();
      drive();
      @(posedge clock);
      @(posedge clock);
      #1;
      resetn = 1'b1;
      q0.push_back({1'b1, 8'hF0}); q1.push_back({1'b1, 8'hF1});
      for (int c = 0; c < 5; c++) begin
         tick();
         chk($sformatf("post-reset grant c%0d", c), 32'(s_grant), 32'(eg_rst[c]));
      end

      chk("timeout pulses", 32'(n_timeouts), 32'd1);
      chk("byte count", 32'(tx_log.size()), 32'd22);
      for (int i = 0; i < 22; i++) begin
         if (i < tx_log.size()) chk($sformatf("byte %0d", i), 32'(tx_log[i]), 32'(exp_log[i]));
         else chk($sformatf("byte %0d missing", i), 32'hFFFF_FFFF, 32'(exp_log[i]));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
